// File: rtl/blit_pkg.sv
// rtl/blit_pkg.sv - shared state encoding, shift type and stride default for the sprite blitter
package blit_pkg;

    localparam int ROW_STRIDE_DEFAULT = 32;

    typedef logic [2:0] shamt_t;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD,
        RD0,
        WR0,
        FLUSH,
        RD1,
        WR1,
        NEXT,
        DONE
    } blit_state_t;

endpackage

// File: rtl/shift_register.sv
// rtl/shift_register.sv - two-stage byte shifter; result is the upper byte of {hi,lo} << amount
module shift_register
    import blit_pkg::*;
#(
    parameter int XLEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [XLEN-1:0] din,
    input  logic [2:0]      amount,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [2*XLEN-1:0] shifted;

    // Each write pushes the new byte into hi and moves the old hi down to lo.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we) begin
            hi_d = din;
            lo_d = hi_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign shifted = {hi_q, lo_q} << amount;
    assign result  = shifted[2*XLEN-1:XLEN];

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite row blitter FSM; SPRITE_BLITTER_OR_EN enables read-OR-write merging
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int XLEN       = 8,
    parameter int AW         = 16,
    parameter int ROW_STRIDE = ROW_STRIDE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   src_addr,
    input  logic [AW-1:0]   dst_addr,
    input  logic [7:0]      height,
    input  logic [2:0]      shift,
    output logic            busy,
    output logic            done,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    blit_state_t     state_q, state_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [7:0]      height_q, height_d;
    logic [7:0]      row_q, row_d;
    shamt_t          k_q, k_d;
    logic [XLEN-1:0] s_q, s_d;
    logic            done_q, done_d;

    logic            sh_we;
    logic [XLEN-1:0] sh_din;
    logic [XLEN-1:0] sh_result;
    logic [XLEN-1:0] wr_byte;

`ifdef SPRITE_BLITTER_OR_EN
    logic [XLEN-1:0] bg_q, bg_d;
    assign wr_byte = sh_result | bg_q;
`else
    assign wr_byte = sh_result;
`endif

    shift_register #(
        .XLEN (XLEN)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .we     (sh_we),
        .din    (sh_din),
        .amount (k_q),
        .result (sh_result)
    );

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        height_d  = height_q;
        row_d     = row_q;
        k_d       = k_q;
        s_d       = s_q;
`ifdef SPRITE_BLITTER_OR_EN
        bg_d      = bg_q;
`endif
        sh_we     = 1'b0;
        sh_din    = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done_d    = (state_q == DONE);

        case (state_q)
            IDLE: begin
                // A start landing on the done pulse belongs to the finished command's handshake.
                if (start && !done_q) begin
                    src_d    = src_addr;
                    dst_d    = dst_addr;
                    height_d = height;
                    k_d      = shift;
                    row_d    = '0;
                    state_d  = (height == 8'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = src_q;
                if (mem_ack) begin
                    s_d     = mem_rdata;
                    sh_we   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sh_we  = 1'b1;
                sh_din = s_q;
`ifdef SPRITE_BLITTER_OR_EN
                state_d = RD0;
`else
                state_d = WR0;
`endif
            end
`ifdef SPRITE_BLITTER_OR_EN
            RD0: begin
                mem_req  = 1'b1;
                mem_addr = dst_q;
                if (mem_ack) begin
                    bg_d    = mem_rdata;
                    state_d = WR0;
                end
            end
            RD1: begin
                mem_req  = 1'b1;
                mem_addr = dst_q + AW'(1);
                if (mem_ack) begin
                    bg_d    = mem_rdata;
                    state_d = WR1;
                end
            end
`endif
            WR0: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = wr_byte;
                if (mem_ack) state_d = FLUSH;
            end
            FLUSH: begin
                sh_we = 1'b1;
`ifdef SPRITE_BLITTER_OR_EN
                state_d = RD1;
`else
                state_d = WR1;
`endif
            end
            WR1: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_q + AW'(1);
                mem_wdata = wr_byte;
                if (mem_ack) state_d = NEXT;
            end
            NEXT: begin
                row_d   = row_q + 8'd1;
                src_d   = src_q + AW'(1);
                dst_d   = dst_q + AW'(ROW_STRIDE);
                state_d = (row_q + 8'd1 == height_q) ? DONE : FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            height_q <= '0;
            row_q    <= '0;
            k_q      <= '0;
            s_q      <= '0;
            done_q   <= 1'b0;
`ifdef SPRITE_BLITTER_OR_EN
            bg_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            height_q <= height_d;
            row_q    <= row_d;
            k_q      <= k_d;
            s_q      <= s_d;
            done_q   <= done_d;
`ifdef SPRITE_BLITTER_OR_EN
            bg_q     <= bg_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - randomized scoreboard bench for sprite_blitter with literal anchor cases
module tb_sprite_blitter;

`ifdef SPRITE_BLITTER_OR_EN
    localparam bit       OR_EN  = 1'b1;
    localparam int       ROWCYC = 8;
    localparam bit [7:0] BG     = 8'h00;
`else
    localparam bit       OR_EN  = 1'b0;
    localparam int       ROWCYC = 6;
    localparam bit [7:0] BG     = 8'hEE;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] src_addr, dst_addr;
    logic [7:0]  height;
    logic [2:0]  shift;
    logic        busy, done;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    sprite_blitter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .height    (height),
        .shift     (shift),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    acc_t       exp_q[$];
    logic [7:0] mem [0:65535];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int req_cyc = 0;
    int wait_mode = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: sprite rows processed in order, each a source read then two shifted byte writes.
    task automatic build_model(input logic [15:0] src, input logic [15:0] dst, input int h, input int k);
        logic [7:0]  ov [int];
        logic [15:0] sa, a0, a1;
        int          s, b0, b1;
        acc_t        e;
        for (int r = 0; r < h; r++) begin
            sa = src + 16'(r);
            s  = ov.exists(int'(sa)) ? int'(ov[int'(sa)]) : int'(mem[sa]);
            e.we = 1'b0; e.addr = sa; e.data = 8'h00; exp_q.push_back(e);
            a0 = dst + 16'(r * 32);
            a1 = a0 + 16'd1;
            b0 = (s << k) & 255;
            b1 = (s << k) >> 8;
            if (OR_EN) begin
                e.we = 1'b0; e.addr = a0; e.data = 8'h00; exp_q.push_back(e);
                b0 = b0 | (ov.exists(int'(a0)) ? int'(ov[int'(a0)]) : int'(mem[a0]));
            end
            e.we = 1'b1; e.addr = a0; e.data = 8'(b0); exp_q.push_back(e);
            ov[int'(a0)] = 8'(b0);
            if (OR_EN) begin
                e.we = 1'b0; e.addr = a1; e.data = 8'h00; exp_q.push_back(e);
                b1 = b1 | (ov.exists(int'(a1)) ? int'(ov[int'(a1)]) : int'(mem[a1]));
            end
            e.we = 1'b1; e.addr = a1; e.data = 8'(b1); exp_q.push_back(e);
            ov[int'(a1)] = 8'(b1);
        end
    endtask

    // Memory responder and per-cycle output checker.
    initial begin : responder
        bit          pend;
        logic        pwe;
        logic [15:0] paddr;
        logic [7:0]  pwd;
        int          cnt, cur_w;
        acc_t        e;
        pend = 0; cnt = 0; cur_w = 0;
        pwe = 1'b0; paddr = '0; pwd = '0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (!rst) begin
                pend = 0;
                cnt  = 0;
                continue;
            end
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (mem_req) req_cyc++;
            if (pend) begin
                chk("hold_req", {31'd0, mem_req}, 1);
                chk("hold_we", {31'd0, mem_we}, {31'd0, pwe});
                chk("hold_addr", {16'd0, mem_addr}, {16'd0, paddr});
                chk("hold_wdata", {24'd0, mem_wdata}, {24'd0, pwd});
            end
            if (mem_req) begin
                if (cnt == 0) cur_w = (wait_mode == 0) ? 0 : (wait_mode == 1) ? 3 : int'($urandom_range(0, 3));
                if (cnt == cur_w) begin
                    mem_ack = 1'b1;
                    if (!mem_we) mem_rdata = mem[mem_addr];
                    chk("access_expected", {31'd0, exp_q.size() != 0}, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("acc_we", {31'd0, mem_we}, {31'd0, e.we});
                        chk("acc_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                        if (e.we) chk("acc_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
                    end
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
            end
            pend  = mem_req && !mem_ack;
            pwe   = mem_we;
            paddr = mem_addr;
            pwd   = mem_wdata;
        end
    end

    task automatic run_cmd(input logic [15:0] src, input logic [15:0] dst, input int h, input int k, input bit poke);
        int t0, d0, r0;
        build_model(src, dst, h, k);
        d0 = done_cnt;
        r0 = req_cyc;
        @(posedge clk); #1;
        start = 1'b1; src_addr = src; dst_addr = dst; height = 8'(h); shift = 3'(k);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        src_addr = 16'($urandom); dst_addr = 16'($urandom);
        height = 8'($urandom); shift = 3'($urandom);
        if (poke) begin
            // For height 0 this lands exactly on the done cycle; otherwise mid-command.
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clk);
        chk("done_seen", {31'd0, done_cnt > d0}, 1);
        if (wait_mode == 0) chk("latency", 32'(last_done_cyc - t0), 32'(ROWCYC * h + 2));
        repeat (12) @(negedge clk);
        chk("single_done", 32'(done_cnt - d0), 1);
        chk("idle_after", {31'd0, busy}, 0);
        chk("model_drained", 32'(exp_q.size()), 0);
        if (h == 0) chk("empty_no_req", 32'(req_cyc - r0), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : main
        int          d0;
        bit          found;
        logic [15:0] rs, rd;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; height = '0; shift = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_req", {31'd0, mem_req}, 0);
        chk("rst_we", {31'd0, mem_we}, 0);
        chk("rst_addr", {16'd0, mem_addr}, 0);
        chk("rst_wdata", {24'd0, mem_wdata}, 0);
        @(posedge clk); #1; rst = 1'b1;

        wait_mode = 0;
        mem[16'h1000] = 8'hFF; mem[16'h3000] = BG; mem[16'h3001] = BG;
        run_cmd(16'h1000, 16'h3000, 1, 3, 1'b0);
        chk("basic_b0", {24'd0, mem[16'h3000]}, 32'h F8);
        chk("basic_b1", {24'd0, mem[16'h3001]}, 32'h 07);

        mem[16'h1100] = 8'hA5; mem[16'h1101] = 8'h3C;
        mem[16'h2400] = BG; mem[16'h2401] = BG; mem[16'h2420] = BG; mem[16'h2421] = BG;
        run_cmd(16'h1100, 16'h2400, 2, 0, 1'b0);
        chk("noshift_2400", {24'd0, mem[16'h2400]}, 32'h A5);
        chk("noshift_2401", {24'd0, mem[16'h2401]}, 32'h 00);
        chk("noshift_2420", {24'd0, mem[16'h2420]}, 32'h 3C);
        chk("noshift_2421", {24'd0, mem[16'h2421]}, 32'h 00);

        wait_mode = 1;
        mem[16'h3100] = BG; mem[16'h3101] = BG;
        run_cmd(16'h1000, 16'h3100, 1, 3, 1'b0);
        chk("wait_b0", {24'd0, mem[16'h3100]}, 32'h F8);
        chk("wait_b1", {24'd0, mem[16'h3101]}, 32'h 07);

        wait_mode = 0;
        run_cmd(16'h1000, 16'h3000, 0, 5, 1'b1);
        run_cmd(16'h1100, 16'h2500, 2, 4, 1'b1);

        mem[16'h1200] = 8'h01; mem[16'hFFFF] = BG; mem[16'h0000] = BG;
        run_cmd(16'h1200, 16'hFFFF, 1, 7, 1'b0);
        chk("wrap_ffff", {24'd0, mem[16'hFFFF]}, 32'h 80);
        chk("wrap_0000", {24'd0, mem[16'h0000]}, 32'h 00);

        wait_mode = 1;
        build_model(16'h1000, 16'h3300, 3, 2);
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; src_addr = 16'h1000; dst_addr = 16'h3300; height = 8'd3; shift = 3'd2;
        @(posedge clk); #1; start = 1'b0;
        found = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (mem_req && mem_we && mem_addr == 16'h3320) begin
                found = 1;
                break;
            end
        end
        chk("rst_found_wr0", {31'd0, found}, 1);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst_req", {31'd0, mem_req}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        @(posedge clk); #1; rst = 1'b1;
        exp_q.delete();
        repeat (10) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt - d0), 0);
        wait_mode = 0;
        mem[16'h3400] = BG; mem[16'h3401] = BG;
        run_cmd(16'h1000, 16'h3400, 1, 3, 1'b0);
        chk("post_rst_b0", {24'd0, mem[16'h3400]}, 32'h F8);
        chk("post_rst_b1", {24'd0, mem[16'h3401]}, 32'h 07);

`ifdef SPRITE_BLITTER_OR_EN
        mem[16'h1300] = 8'hF0; mem[16'h3200] = 8'h0F; mem[16'h3201] = 8'h0F;
        run_cmd(16'h1300, 16'h3200, 1, 0, 1'b0);
        chk("or_b0", {24'd0, mem[16'h3200]}, 32'h FF);
        chk("or_b1", {24'd0, mem[16'h3201]}, 32'h 0F);
`endif

        for (int n = 0; n < 20; n++) begin
            wait_mode = int'($urandom_range(0, 2));
            rs = 16'($urandom);
            rd = 16'($urandom);
            run_cmd(rs, rd, int'($urandom_range(0, 6)), int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
        end

        wait_mode = 0;
        run_cmd(16'h8000, 16'h4000, 255, 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
